if_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the 5-stage RV32I pipeline; producer side of the IF/ID interface consumed by decode.

---
 rtl/if_fetch_stage.sv | 134 +++++++++++++
 tb/tb_if_fetch_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, JAL/branch prediction and the IF/ID register.
// Define IF_BHT_EN for dynamic 2-bit BHT prediction; otherwise branches use backward-taken.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 16,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        EX_flush,
    input  logic [31:0] EX_redirect_pc,
    input  logic        EX_branch_valid,
    input  logic [31:0] EX_branch_pc,
    input  logic        EX_branch_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instruction,
    output logic [31:0] IF_ID_pc,
    output logic        IF_ID_take,
    output logic        IF_ID_valid
);
    localparam int         IDX_W     = $clog2(BHT_ENTRIES);
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc_q, if_id_pc_d;
    logic        if_id_take_q, if_id_take_d;
    logic        if_id_valid_q, if_id_valid_d;

    logic [6:0]  op;
    logic [31:0] j_imm, b_imm, next_pc;
    logic        take, branch_pred;

`ifdef IF_BHT_EN
    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [1:0]       bht_d [BHT_ENTRIES];
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             unused_bpc_bits;

    assign rd_idx          = pc_q[IDX_W+1:2];
    assign wr_idx          = EX_branch_pc[IDX_W+1:2];
    assign branch_pred     = bht_q[rd_idx][1];
    assign unused_bpc_bits = ^{EX_branch_pc[31:IDX_W+2], EX_branch_pc[1:0]};

    // Prediction reads bht_q, so a same-cycle update to the same entry is not seen yet.
    always_comb begin
        bht_d = bht_q;
        if (EX_branch_valid) begin
            if (EX_branch_taken) begin
                if (bht_q[wr_idx] != 2'b11) bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
            end else begin
                if (bht_q[wr_idx] != 2'b00) bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
        end else begin
            bht_q <= bht_d;
        end
    end
`else
    logic unused_ex_branch;

    assign branch_pred      = imem_rdata[31];
    assign unused_ex_branch = ^{EX_branch_valid, EX_branch_pc, EX_branch_taken};
`endif

    always_comb begin
        op      = imem_rdata[6:0];
        j_imm   = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                   imem_rdata[20], imem_rdata[30:21], 1'b0};
        b_imm   = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                   imem_rdata[30:25], imem_rdata[11:8], 1'b0};
        take    = 1'b0;
        next_pc = pc_q + 32'd4;
        if (op == OP_JAL) begin
            take    = 1'b1;
            next_pc = pc_q + j_imm;
        end else if (op == OP_BRANCH) begin
            take = branch_pred;
            if (branch_pred) next_pc = pc_q + b_imm;
        end
    end

    always_comb begin
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_take_d  = if_id_take_q;
        if_id_valid_d = if_id_valid_q;
        if (EX_flush) begin
            pc_d          = EX_redirect_pc;
            if_id_instr_d = NOP_INSTR;
            if_id_pc_d    = 32'd0;
            if_id_take_d  = 1'b0;
            if_id_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d          = next_pc;
            if_id_instr_d = imem_rdata;
            if_id_pc_d    = pc_q;
            if_id_take_d  = take;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= 32'd0;
            if_id_take_q  <= 1'b0;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_take_q  <= if_id_take_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign imem_addr         = pc_q;
    assign IF_ID_instruction = if_id_instr_q;
    assign IF_ID_pc          = if_id_pc_q;
    assign IF_ID_take        = if_id_take_q;
    assign IF_ID_valid       = if_id_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random traffic against a reference model.
module tb_if_fetch_stage;
    localparam int          N   = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, stall, EX_flush, EX_branch_valid, EX_branch_taken;
    logic [31:0] EX_redirect_pc, EX_branch_pc, imem_rdata, imem_addr;
    logic [31:0] IF_ID_instruction, IF_ID_pc;
    logic        IF_ID_take, IF_ID_valid;

    always #5 clk = ~clk;

    if_fetch_stage #(.RESET_PC(32'h0), .BHT_ENTRIES(N), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .EX_flush(EX_flush),
        .EX_redirect_pc(EX_redirect_pc), .EX_branch_valid(EX_branch_valid),
        .EX_branch_pc(EX_branch_pc), .EX_branch_taken(EX_branch_taken),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .IF_ID_instruction(IF_ID_instruction), .IF_ID_pc(IF_ID_pc),
        .IF_ID_take(IF_ID_take), .IF_ID_valid(IF_ID_valid)
    );

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_pc, m_instr, m_ipc;
    bit          m_take, m_valid, m_known = 0;
    int          m_bht [N];

    // One clock cycle: drive at negedge, compare the fetch address, predict, compare IF/ID after the edge.
    task automatic step(input bit rst, input bit st, input bit fl, input logic [31:0] rpc,
                        input bit bv, input logic [31:0] bpc, input bit bt, input logic [31:0] w);
        int          off;
        bit          tk;
        logic [31:0] nxt;
        @(negedge clk);
        rst_n = ~rst; stall = st; EX_flush = fl; EX_redirect_pc = rpc;
        EX_branch_valid = bv; EX_branch_pc = bpc; EX_branch_taken = bt; imem_rdata = w;
        #1;
        if (m_known) check_eq("imem_addr", imem_addr, m_pc);
        tk  = 0;
        nxt = m_pc + 32'd4;
        if (w[6:0] == 7'b1101111) begin
            off = int'({w[19:12], w[20], w[30:21], 1'b0}) - (w[31] ? (1 << 20) : 0);
            tk  = 1;
            nxt = m_pc + off;
        end else if (w[6:0] == 7'b1100011) begin
            off = int'({w[7], w[30:25], w[11:8], 1'b0}) - (w[31] ? (1 << 12) : 0);
`ifdef IF_BHT_EN
            tk = (m_bht[(m_pc >> 2) % N] >= 2);
`else
            tk = w[31];
`endif
            if (tk) nxt = m_pc + off;
        end
        if (rst) begin
            m_pc = 32'h0; m_instr = NOP; m_ipc = 0; m_take = 0; m_valid = 0; m_known = 1;
            for (int i = 0; i < N; i++) m_bht[i] = 1;
        end else begin
`ifdef IF_BHT_EN
            if (bv) begin
                if (bt) m_bht[(bpc >> 2) % N] = (m_bht[(bpc >> 2) % N] == 3) ? 3 : m_bht[(bpc >> 2) % N] + 1;
                else    m_bht[(bpc >> 2) % N] = (m_bht[(bpc >> 2) % N] == 0) ? 0 : m_bht[(bpc >> 2) % N] - 1;
            end
`endif
            if (fl) begin
                m_pc = rpc; m_instr = NOP; m_ipc = 0; m_take = 0; m_valid = 0;
            end else if (!st) begin
                m_ipc = m_pc; m_instr = w; m_take = tk; m_valid = 1; m_pc = nxt;
            end
        end
        @(posedge clk);
        #1;
        check_eq("if_id_instruction", IF_ID_instruction, m_instr);
        check_eq("if_id_pc", IF_ID_pc, m_ipc);
        check_eq("if_id_take", {31'd0, IF_ID_take}, {31'd0, m_take});
        check_eq("if_id_valid", {31'd0, IF_ID_valid}, {31'd0, m_valid});
    endtask

    initial begin
        logic [31:0] r, w, rpc, bpc;
        int          kind;

        // Reset
        step(1, 0, 0, 0, 0, 0, 0, NOP);
        step(1, 0, 0, 0, 0, 0, 0, NOP);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_instr", IF_ID_instruction, NOP);
        check_eq("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        check_eq("rst_take", {31'd0, IF_ID_take}, 32'd0);

        // Sequential fetch
        for (int i = 0; i < 4; i++) begin
            check_eq("seq_addr", imem_addr, 32'(4 * i));
            step(0, 0, 0, 0, 0, 0, 0, NOP);
        end
        check_eq("seq_ifid_pc", IF_ID_pc, 32'hC);
        check_eq("seq_valid", {31'd0, IF_ID_valid}, 32'd1);

        // JAL +0x20 at 0x10
        step(0, 0, 0, 0, 0, 0, 0, 32'h020000EF);
        check_eq("jal_addr", imem_addr, 32'h30);
        check_eq("jal_take", {31'd0, IF_ID_take}, 32'd1);
        check_eq("jal_ifid_pc", IF_ID_pc, 32'h10);

        // Stall at 0x8, then stall+flush together
        step(0, 0, 1, 32'h8, 0, 0, 0, NOP);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 32'h020000EF);
        check_eq("stall_addr", imem_addr, 32'h8);
        step(0, 1, 1, 32'h40, 0, 0, 0, NOP);
        check_eq("sflush_addr", imem_addr, 32'h40);
        check_eq("sflush_instr", IF_ID_instruction, NOP);
        check_eq("sflush_valid", {31'd0, IF_ID_valid}, 32'd0);

`ifdef IF_BHT_EN
        step(0, 0, 1, 32'h20, 0, 0, 0, NOP);
        step(0, 1, 0, 0, 1, 32'h20, 1, NOP);
        step(0, 1, 0, 0, 1, 32'h20, 1, NOP);
        step(0, 0, 0, 0, 0, 0, 0, 32'hFE000CE3);
        check_eq("bht_t_addr", imem_addr, 32'h18);
        check_eq("bht_t_take", {31'd0, IF_ID_take}, 32'd1);
        step(0, 0, 1, 32'h20, 0, 0, 0, NOP);
        step(0, 1, 0, 0, 1, 32'h20, 0, NOP);
        step(0, 1, 0, 0, 1, 32'h20, 0, NOP);
        step(0, 0, 0, 0, 0, 0, 0, 32'hFE000CE3);
        check_eq("bht_nt_addr", imem_addr, 32'h24);
        check_eq("bht_nt_take", {31'd0, IF_ID_take}, 32'd0);
`else
        step(0, 0, 0, 0, 1, 32'h40, 0, 32'hFE000CE3);
        check_eq("bwd_addr", imem_addr, 32'h38);
        check_eq("bwd_take", {31'd0, IF_ID_take}, 32'd1);
        step(0, 0, 0, 0, 1, 32'h38, 1, 32'h00000463);
        check_eq("fwd_addr", imem_addr, 32'h3C);
        check_eq("fwd_take", {31'd0, IF_ID_take}, 32'd0);
`endif

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            r    = $urandom();
            kind = $urandom_range(0, 5);
            case (kind)
                0: w = NOP;
                1: w = {r[31:7], 7'b1101111};
                2, 3: w = {r[31:7], 7'b1100011};
                4: w = {r[31:7], 7'b1100111};
                default: w = r;
            endcase
            rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            bpc = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            step($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0, rpc, $urandom_range(0, 2) == 0,
                 bpc, $urandom_range(0, 1) == 1, w);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
